dsp_share_arbiter: RTL and testbench
====================================

// Module: dsp_share_arbiter
// PURPOSE
//  Time-shares one fixed-latency, non-stallable DSP core, P = A*(B op D) + C, among NREQ requesters.
//  Each requester uses a valid/ready request port and a valid/ready result port.
//  Round-robin arbitration; at most one operation issued per cycle; an in-flight tag pipeline routes each P back.
//  Sits between client engines (filters, MAC loops) and the single DSP instance.
// PARAMETERS
//  NREQ     4   number of requesters (2..8)
//  DSP_LAT  4   clock edges from core operand ports to valid dsp_p; tag pipeline depth
//  AW       18  width of A, B and D operands
//  CW       48  width of C and P
// PORTS
//  clk        in   1        clock, rising edge
//  rst_n      in   1        synchronous active-low reset
//  req_valid  in   NREQ     per-requester operation request
//  req_ready  out  NREQ     per-requester grant; transfer when valid&ready
//  req_a      in   NREQ*AW  operand A; requester i uses [i*AW +: AW]; likewise req_b and req_d
//  req_b      in   NREQ*AW  operand B
//  req_d      in   NREQ*AW  operand D
//  req_c      in   NREQ*CW  operand C
//  res_valid  out  NREQ     result held for requester i
//  res_ready  in   NREQ     requester i accepts its result
//  res_p      out  NREQ*CW  per-requester result hold registers
//  dsp_a      out  AW       registered operand ports to the core; dsp_b and dsp_d likewise
//  dsp_b      out  AW       registered operand B to the core
//  dsp_d      out  AW       registered operand D to the core
//  dsp_c      out  CW       registered operand C to the core
//  dsp_p      in   CW       core result
//  idle       out  1        no busy requester and tag pipeline empty
//  issue_cnt  out  16       wrapping count of issued operations
// BEHAVIOUR
//  - Reset (rst_n=0 at an edge) sets to zero: req_ready, res_valid, res_p, dsp_*, busy[], tag pipeline, rr_ptr and issue_cnt; idle reads 1.
//  - Reset mid-operation discards all in-flight results; no res_valid is raised for them.
//  - busy[i]: set on request handshake i; cleared on the edge where res_valid[i]&res_ready[i]. A requester has at most one op outstanding.
//  - Eligibility and grant (combinational):
//    - eligible[i] = req_valid[i] & ~busy[i] & ~res_valid[i].
//    - Winner is the first eligible index scanning rr_ptr, rr_ptr+1, ... modulo NREQ.
//    - req_ready is one-hot on the winner, or zero if none; it must not depend on req_valid of other ports beyond this rule.
//  - Issue, at the handshake edge t:
//    - dsp_a/b/c/d load the winner's operands.
//    - tag_v[0]<=1 and tag_id[0]<=winner.
//    - rr_ptr<=(winner+1)%NREQ.
//    - issue_cnt increments and wraps at 2^16.
//  - With no issue, dsp_* load 0 and tag_v[0]<=0. rr_ptr holds.
//  - The tag pipeline shifts every edge and is never stalled; the core cannot stall.
//  - Capture, at edge t+DSP_LAT (tag_v[DSP_LAT-1]=1): res_p[id]<=dsp_p and res_valid[id]<=1.
//  - Latency: handshake edge t to res_valid high after edge t+DSP_LAT, i.e. DSP_LAT+1 cycles from the handshake cycle. Throughput is 1 op/cycle when requesters differ.
//  - Result hold: res_valid[i] and res_p[i] stay stable until res_ready[i]. The capture target is always idle (busy protocol), so no result collision or overwrite is possible.
//  - Re-issue: requester i is eligible again from the cycle after its result accept edge. Same-cycle accept and re-request is not granted.
//  - Arithmetic: no width changes; operands are passed unmodified and the core's OPERATION setting governs add/subtract.
//  - idle = ~|busy & ~|tag_v.
// TESTING
//  - Reset: hold rst_n=0 3 cycles with all req_valid=1 -> req_ready=0, res_valid=0, dsp_*=0, idle=1.
//  - Single op, core ADD, DSP_LAT=4: req 0 with A=3, B=2, D=5, C=10 -> res_valid[0] 5 cycles after the handshake, res_p[0]=31, idle=0 until accepted.
//  - All 4 requesting from reset (rr_ptr=0): grants 0,1,2,3 on consecutive cycles; results arrive in the same order on consecutive cycles; issue_cnt=4.
//  - Back-to-back: requester 2 holds valid with res_ready=1 -> second grant only on the cycle after its first result is accepted.
//  - Backpressure: res_ready[1]=0 for 20 cycles -> res_p[1] stable, req_ready[1]=0 throughout, other requesters keep issuing.
//  - Reset 2 cycles after issuing to requesters 0 and 1 -> no res_valid afterwards, busy cleared, both regranted after reset release.

Source files
------------

// File: rtl/dsp_share_arbiter.sv
// Round-robin time-sharing of one fixed-latency, non-stallable DSP core (P = A*(B op D) + C)
// among NREQ requesters; an in-flight tag pipeline routes each core result back to its owner.
module dsp_share_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned DSP_LAT = 4,
  parameter int unsigned AW      = 18,
  parameter int unsigned CW      = 48
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*AW-1:0]   req_a,
  input  logic [NREQ*AW-1:0]   req_b,
  input  logic [NREQ*AW-1:0]   req_d,
  input  logic [NREQ*CW-1:0]   req_c,
  output logic [NREQ-1:0]      res_valid,
  input  logic [NREQ-1:0]      res_ready,
  output logic [NREQ*CW-1:0]   res_p,
  output logic [AW-1:0]        dsp_a,
  output logic [AW-1:0]        dsp_b,
  output logic [AW-1:0]        dsp_d,
  output logic [CW-1:0]        dsp_c,
  input  logic [CW-1:0]        dsp_p,
  output logic                 idle,
  output logic [15:0]          issue_cnt
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned SW = IW + 1;

  logic [NREQ-1:0]    busy;
  logic [NREQ-1:0]    eligible;
  logic [IW-1:0]      rr_ptr;
  logic [IW-1:0]      win_idx;
  logic [IW-1:0]      rr_next;
  logic               win_found;
  logic               issue;
  logic [SW-1:0]      scan;
  logic [DSP_LAT-1:0] tag_v;
  logic [IW-1:0]      tag_id [DSP_LAT];

  assign eligible = req_valid & ~busy & ~res_valid;

  // First eligible requester scanning from rr_ptr, wrapping modulo NREQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan      = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan = SW'(rr_ptr) + SW'(k);
      if (scan >= SW'(NREQ)) begin
        scan = scan - SW'(NREQ);
      end
      if (!win_found && eligible[scan[IW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = scan[IW-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (rst_n && win_found) begin
      req_ready[win_idx] = 1'b1;
    end
  end

  // The winner is already valid, so a grant is always a handshake.
  assign issue   = rst_n & win_found;
  assign rr_next = (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + IW'(1);
  assign idle    = ~|busy & ~|tag_v;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy      <= '0;
      rr_ptr    <= '0;
      issue_cnt <= '0;
      dsp_a     <= '0;
      dsp_b     <= '0;
      dsp_d     <= '0;
      dsp_c     <= '0;
      tag_v     <= '0;
      res_valid <= '0;
      res_p     <= '0;
      for (int k = 0; k < DSP_LAT; k++) begin
        tag_id[k] <= '0;
      end
    end else begin
      dsp_a <= '0;
      dsp_b <= '0;
      dsp_d <= '0;
      dsp_c <= '0;
      if (issue) begin
        dsp_a         <= req_a[win_idx*AW +: AW];
        dsp_b         <= req_b[win_idx*AW +: AW];
        dsp_d         <= req_d[win_idx*AW +: AW];
        dsp_c         <= req_c[win_idx*CW +: CW];
        busy[win_idx] <= 1'b1;
        rr_ptr        <= rr_next;
        issue_cnt     <= issue_cnt + 16'd1;
      end

      // Tag pipeline shifts unconditionally, matching the non-stallable core.
      tag_v     <= {tag_v[DSP_LAT-2:0], issue};
      tag_id[0] <= win_idx;
      for (int k = 1; k < DSP_LAT; k++) begin
        tag_id[k] <= tag_id[k-1];
      end

      // Capture target is busy with no pending result, so it never collides with an accept.
      if (tag_v[DSP_LAT-1]) begin
        res_p[tag_id[DSP_LAT-1]*CW +: CW] <= dsp_p;
        res_valid[tag_id[DSP_LAT-1]]      <= 1'b1;
      end

      for (int i = 0; i < NREQ; i++) begin
        if (res_valid[i] && res_ready[i]) begin
          res_valid[i] <= 1'b0;
          busy[i]      <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_dsp_share_arbiter.sv
// Directed self-checking bench for dsp_share_arbiter; a small ADD-mode core model feeds dsp_p.
module tb_dsp_share_arbiter;

  localparam int unsigned NREQ    = 4;
  localparam int unsigned DSP_LAT = 4;
  localparam int unsigned AW      = 18;
  localparam int unsigned CW      = 48;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*AW-1:0]  req_a;
  logic [NREQ*AW-1:0]  req_b;
  logic [NREQ*AW-1:0]  req_d;
  logic [NREQ*CW-1:0]  req_c;
  logic [NREQ-1:0]     res_valid;
  logic [NREQ-1:0]     res_ready;
  logic [NREQ*CW-1:0]  res_p;
  logic [AW-1:0]       dsp_a;
  logic [AW-1:0]       dsp_b;
  logic [AW-1:0]       dsp_d;
  logic [CW-1:0]       dsp_c;
  logic [CW-1:0]       dsp_p;
  logic                idle;
  logic [15:0]         issue_cnt;

  int checks = 0;
  int errors = 0;
  logic [15:0] cnt0;

  // Core model: operand ports count as the first of DSP_LAT edges.
  logic [CW-1:0] p_pipe [DSP_LAT-1] = '{default: '0};

  always #5 clk = ~clk;

  always @(posedge clk) begin
    p_pipe[0] <= CW'(dsp_a) * (CW'(dsp_b) + CW'(dsp_d)) + dsp_c;
    for (int k = 1; k < DSP_LAT - 1; k++) p_pipe[k] <= p_pipe[k-1];
  end
  assign dsp_p = p_pipe[DSP_LAT-2];

  dsp_share_arbiter #(.NREQ(NREQ), .DSP_LAT(DSP_LAT), .AW(AW), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_d(req_d), .req_c(req_c),
    .res_valid(res_valid), .res_ready(res_ready), .res_p(res_p),
    .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_d(dsp_d), .dsp_c(dsp_c), .dsp_p(dsp_p),
    .idle(idle), .issue_cnt(issue_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [AW-1:0] a, input logic [AW-1:0] b,
                        input logic [AW-1:0] d, input logic [CW-1:0] c);
    req_a[i*AW +: AW] = a;
    req_b[i*AW +: AW] = b;
    req_d[i*AW +: AW] = d;
    req_c[i*CW +: CW] = c;
  endtask

  function automatic logic [63:0] p_of(input int i);
    return 64'(res_p[i*CW +: CW]);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = '1;
    res_ready = '0;
    req_a     = '0;
    req_b     = '0;
    req_d     = '0;
    req_c     = '0;

    // Reset held 3 cycles with every requester asking.
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(req_ready), 64'h0);
    check("rst_resv",  64'(res_valid), 64'h0);
    check("rst_dspa",  64'(dsp_a), 64'h0);
    check("rst_dspc",  64'(dsp_c), 64'h0);
    check("rst_idle",  64'(idle), 64'h1);
    check("rst_cnt",   64'(issue_cnt), 64'h0);
    rst_n     = 1'b1;
    req_valid = '0;

    // Single op: 3*(2+5)+10 = 31.
    @(negedge clk);
    set_op(0, 18'd3, 18'd2, 18'd5, 48'd10);
    req_valid = 4'b0001;
    #1 check("t1_ready", 64'(req_ready), 64'h1);
    @(negedge clk);
    req_valid = '0;
    check("t1_dspa", 64'(dsp_a), 64'd3);
    check("t1_dspb", 64'(dsp_b), 64'd2);
    check("t1_dspd", 64'(dsp_d), 64'd5);
    check("t1_dspc", 64'(dsp_c), 64'd10);
    check("t1_cnt",  64'(issue_cnt), 64'd1);
    check("t1_busy_idle", 64'(idle), 64'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t1_wait_resv", 64'(res_valid), 64'h0);
      check("t1_dsp_zero", 64'(dsp_a), 64'h0);
    end
    @(negedge clk);
    check("t1_resv", 64'(res_valid), 64'h1);
    check("t1_resp", p_of(0), 64'd31);
    check("t1_idle_held", 64'(idle), 64'h0);
    req_valid = 4'b0001;
    #1 check("t1_no_regrant", 64'(req_ready), 64'h0);
    @(negedge clk);
    check("t1_hold", p_of(0), 64'd31);
    res_ready = 4'b0001;
    #1 check("t1_same_cycle", 64'(req_ready), 64'h0);
    @(negedge clk);
    check("t1_accepted", 64'(res_valid), 64'h0);
    check("t1_idle", 64'(idle), 64'h1);
    check("t1_regrant", 64'(req_ready), 64'h1);
    req_valid = '0;
    res_ready = '0;

    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // All four from rr_ptr=0: results 3, 108, 215, 324.
    set_op(0, 18'd1, 18'd2, 18'd1, 48'd0);
    set_op(1, 18'd2, 18'd3, 18'd1, 48'd100);
    set_op(2, 18'd3, 18'd4, 18'd1, 48'd200);
    set_op(3, 18'd4, 18'd5, 18'd1, 48'd300);
    req_valid = 4'b1111;
    #1 check("t2_g0", 64'(req_ready), 64'h1);
    @(negedge clk);
    check("t2_g1", 64'(req_ready), 64'h2);
    @(negedge clk);
    check("t2_g2", 64'(req_ready), 64'h4);
    @(negedge clk);
    check("t2_g3", 64'(req_ready), 64'h8);
    @(negedge clk);
    check("t2_none", 64'(req_ready), 64'h0);
    check("t2_cnt", 64'(issue_cnt), 64'd4);
    check("t2_nores", 64'(res_valid), 64'h0);
    req_valid = '0;
    @(negedge clk);
    check("t2_r0", 64'(res_valid), 64'h1);
    check("t2_p0", p_of(0), 64'd3);
    @(negedge clk);
    check("t2_r1", 64'(res_valid), 64'h3);
    check("t2_p1", p_of(1), 64'd108);
    @(negedge clk);
    check("t2_r2", 64'(res_valid), 64'h7);
    check("t2_p2", p_of(2), 64'd215);
    @(negedge clk);
    check("t2_r3", 64'(res_valid), 64'hf);
    check("t2_p3", p_of(3), 64'd324);
    check("t2_p0_held", p_of(0), 64'd3);
    res_ready = 4'b1111;
    @(negedge clk);
    check("t2_drained", 64'(res_valid), 64'h0);
    check("t2_idle", 64'(idle), 64'h1);
    res_ready = '0;

    // Requester 2 back-to-back: 1*(1+1)+5 = 7, regrant only after accept edge.
    set_op(2, 18'd1, 18'd1, 18'd1, 48'd5);
    req_valid = 4'b0100;
    res_ready = 4'b0100;
    for (int k = 0; k <= 6; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 5) begin
        check("t3_resv", 64'(res_valid), 64'h4);
        check("t3_resp", p_of(2), 64'd7);
      end
      #1 check("t3_ready", 64'(req_ready[2]), ((k == 0) || (k == 6)) ? 64'h1 : 64'h0);
    end
    @(negedge clk);
    req_valid = '0;
    check("t3_cnt", 64'(issue_cnt), 64'd6);
    repeat (6) @(negedge clk);
    check("t3_idle", 64'(idle), 64'h1);
    check("t3_p2", p_of(2), 64'd7);
    res_ready = '0;

    // Backpressure on requester 1 while 0, 2, 3 keep issuing: 2*(2+2)+1 = 9.
    set_op(0, 18'd1, 18'd1, 18'd0, 48'd0);
    set_op(1, 18'd2, 18'd2, 18'd2, 48'd1);
    set_op(3, 18'd1, 18'd0, 18'd1, 48'd0);
    res_ready = 4'b1101;
    req_valid = 4'b1111;
    for (int k = 0; k < 12 && !res_valid[1]; k++) @(negedge clk);
    check("t4_arrive", 64'(res_valid[1]), 64'h1);
    cnt0 = issue_cnt;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      #1;
      check("t4_p1", p_of(1), 64'd9);
      check("t4_v1", 64'(res_valid[1]), 64'h1);
      check("t4_rdy1", 64'(req_ready[1]), 64'h0);
    end
    check("t4_others", 64'((issue_cnt - cnt0) >= 16'd6), 64'h1);
    req_valid = '0;
    res_ready = 4'b1111;
    repeat (8) @(negedge clk);
    check("t4_idle", 64'(idle), 64'h1);
    res_ready = '0;

    // Reset with two ops in flight discards them.
    req_valid = 4'b0011;
    repeat (2) @(negedge clk);
    req_valid = '0;
    check("t5_busy", 64'(idle), 64'h0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("t5_cnt", 64'(issue_cnt), 64'h0);
    check("t5_idle", 64'(idle), 64'h1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("t5_nores", 64'(res_valid), 64'h0);
    end
    req_valid = 4'b0011;
    #1 check("t5_regrant0", 64'(req_ready), 64'h1);
    @(negedge clk);
    #1 check("t5_regrant1", 64'(req_ready), 64'h2);
    req_valid = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
